prog_sequencer: RTL and testbench

Run-level controller that sits between the test bench and the program counter. It turns the bench's Start handshake into PC base-address loads and a fetch-enable (Run). It watches for the program's halt indication and returns Ack to the bench when each program finishes. It replaces ad-hoc Start handling inside the PC: the PC only needs a load port and an enable.

---
 rtl/prog_sequencer.sv | 115 +++++++++++
 tb/tb_prog_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Run-level controller: turns the Start handshake into PC base loads and a fetch enable, returns Ack on halt.
// Optional cycle counter enabled by PROG_SEQ_CYCLE_COUNT_EN; otherwise CycleCount is tied to 0.
module prog_sequencer #(
    parameter int A     = 10,
    parameter int NPROG = 3,
    parameter int BASE0 = 0,
    parameter int BASE1 = 100,
    parameter int BASE2 = 200,
    parameter int CW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          HaltReq,
    output logic          Run,
    output logic          PcLoadEn,
    output logic [A-1:0]  PcLoadVal,
    output logic          Ack,
    output logic [1:0]    ProgIdx,
    output logic          Overrun,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] NPROG_L = 2'(NPROG);

    state_t state;
    state_t state_nxt;
    logic   start_r;
    logic   post_rst;
    logic   rise;
    logic   fall;
    logic   at_limit;

    // post_rst masks the edge a Start held high across reset would otherwise produce
    assign rise     = Start & ~start_r & ~post_rst;
    assign fall     = ~Start & start_r;
    assign at_limit = (ProgIdx >= NPROG_L);

    function automatic logic [A-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd2:    return A'(BASE1);
            2'd3:    return A'(BASE2);
            default: return A'(BASE0);
        endcase
    endfunction

    // A rising Start outranks everything, including a halt in the same cycle
    always_comb begin
        state_nxt = state;
        if (rise && (state != ARMED)) begin
            state_nxt = at_limit ? DONE : ARMED;
        end else begin
            case (state)
                ARMED:   if (fall) state_nxt = LOAD;
                LOAD:    state_nxt = RUN;
                RUN:     if (HaltReq) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            start_r   <= 1'b0;
            post_rst  <= 1'b1;
            Run       <= 1'b0;
            PcLoadEn  <= 1'b0;
            PcLoadVal <= A'(BASE0);
            Ack       <= 1'b0;
            ProgIdx   <= 2'd0;
            Overrun   <= 1'b0;
        end else begin
            start_r  <= Start;
            post_rst <= 1'b0;
            state    <= state_nxt;
            Run      <= (state_nxt == RUN);
            PcLoadEn <= (state_nxt == LOAD);
            Ack      <= (state_nxt == DONE);
            if (rise && (state != ARMED)) begin
                if (at_limit) begin
                    Overrun <= 1'b1;
                end else begin
                    ProgIdx <= ProgIdx + 2'd1;
                end
            end
            if ((state == ARMED) && fall) begin
                PcLoadVal <= base_of(ProgIdx);
            end
        end
    end

`ifdef PROG_SEQ_CYCLE_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CycleCount <= '0;
        end else if (state_nxt == LOAD) begin
            CycleCount <= '0;
        end else if ((state == RUN) && (CycleCount != {CW{1'b1}})) begin
            CycleCount <= CycleCount + CW'(1);
        end
    end
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed vector table, then randomized Start/HaltReq/Reset against a reference model.
module tb_prog_sequencer;
    localparam int A     = 10;
    localparam int NPROG = 3;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          HaltReq = 1'b0;
    logic          Run;
    logic          PcLoadEn;
    logic [A-1:0]  PcLoadVal;
    logic          Ack;
    logic [1:0]    ProgIdx;
    logic          Overrun;
    logic [CW-1:0] CycleCount;

    prog_sequencer #(
        .A(A), .NPROG(NPROG), .BASE0(0), .BASE1(100), .BASE2(200), .CW(CW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .HaltReq(HaltReq),
        .Run(Run), .PcLoadEn(PcLoadEn), .PcLoadVal(PcLoadVal), .Ack(Ack),
        .ProgIdx(ProgIdx), .Overrun(Overrun), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit rst;
        bit st;
        bit hr;
        bit run;
        bit ld;
        int val;
        bit ack;
        int idx;
        bit ov;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(bit r, bit s, bit h, bit run, bit ld, int val,
                                bit ack, int idx, bit ov, int cnt);
        vec_t v;
        v.rst = r; v.st = s; v.hr = h; v.run = run; v.ld = ld; v.val = val;
        v.ack = ack; v.idx = idx; v.ov = ov; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model, phrased in terms of program phases
    localparam int P_IDLE = 0, P_ARMED = 1, P_LOAD = 2, P_RUN = 3, P_DONE = 4;
    int bases[3] = '{0, 100, 200};
    int m_phase, m_idx, m_val, m_cnt;
    bit m_start_r, m_first, m_ov;

    function automatic void model_step(bit rst, bit st, bit hr);
        bit rise, fall;
        if (rst) begin
            m_phase = P_IDLE; m_start_r = 0; m_first = 1;
            m_idx = 0; m_ov = 0; m_val = bases[0]; m_cnt = 0;
            return;
        end
        rise = st && !m_start_r && !m_first;
        fall = !st && m_start_r;
        if (m_phase == P_RUN) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        if (rise && m_phase != P_ARMED) begin
            if (m_idx < NPROG) begin
                m_idx++;
                m_phase = P_ARMED;
            end else begin
                m_ov = 1;
                m_phase = P_DONE;
            end
        end else if (m_phase == P_ARMED && fall) begin
            m_phase = P_LOAD;
            m_val = bases[m_idx-1];
            m_cnt = 0;
        end else if (m_phase == P_LOAD) begin
            m_phase = P_RUN;
        end else if (m_phase == P_RUN && hr) begin
            m_phase = P_DONE;
        end
        m_start_r = st;
        m_first = 0;
    endfunction

    task automatic apply(input bit rst, input bit st, input bit hr);
        Reset = rst; Start = st; HaltReq = hr;
        @(posedge Clk);
        model_step(rst, st, hr);
        @(negedge Clk);
    endtask

    function automatic int exp_cnt(int c);
`ifdef PROG_SEQ_CYCLE_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    initial begin
        bit st, hr, rst;

        // rst st hr | run ld val ack idx ov cnt
        row(1,0,0, 0,0,0,0,0,0,0);
        row(1,0,0, 0,0,0,0,0,0,0);
        row(0,0,0, 0,0,0,0,0,0,0);
        row(0,1,0, 0,0,0,0,1,0,0);
        row(0,1,0, 0,0,0,0,1,0,0);
        row(0,1,0, 0,0,0,0,1,0,0);
        row(0,0,0, 0,1,0,0,1,0,0);
        row(0,0,0, 1,0,0,0,1,0,0);
        for (int k = 1; k <= 6; k++) row(0,0,0, 1,0,0,0,1,0,k);
        row(0,0,1, 0,0,0,1,1,0,7);
        row(0,0,1, 0,0,0,1,1,0,7);
        row(0,1,0, 0,0,0,0,2,0,7);
        row(0,0,0, 0,1,100,0,2,0,0);
        row(0,0,0, 1,0,100,0,2,0,0);
        row(0,0,0, 1,0,100,0,2,0,1);
        row(0,1,1, 0,0,100,0,3,0,2);
        row(0,0,0, 0,1,200,0,3,0,0);
        row(0,0,0, 1,0,200,0,3,0,0);
        row(0,0,1, 0,0,200,1,3,0,1);
        row(0,1,0, 0,0,200,1,3,1,1);
        row(0,0,0, 0,0,200,1,3,1,1);
        row(0,1,0, 0,0,200,1,3,1,1);
        row(0,0,0, 0,0,200,1,3,1,1);
        row(1,0,0, 0,0,0,0,0,0,0);
        row(0,0,0, 0,0,0,0,0,0,0);
        row(0,1,0, 0,0,0,0,1,0,0);
        row(0,0,0, 0,1,0,0,1,0,0);
        row(0,0,0, 1,0,0,0,1,0,0);
        row(0,0,0, 1,0,0,0,1,0,1);
        row(1,1,0, 0,0,0,0,0,0,0);
        row(0,1,0, 0,0,0,0,0,0,0);
        row(0,1,0, 0,0,0,0,0,0,0);
        row(0,0,0, 0,0,0,0,0,0,0);
        row(0,1,0, 0,0,0,0,1,0,0);
        row(0,0,0, 0,1,0,0,1,0,0);
        row(0,0,0, 1,0,0,0,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].st, tbl[i].hr);
            check($sformatf("vec%0d.Run", i),        32'(Run),        32'(tbl[i].run));
            check($sformatf("vec%0d.PcLoadEn", i),   32'(PcLoadEn),   32'(tbl[i].ld));
            check($sformatf("vec%0d.PcLoadVal", i),  32'(PcLoadVal),  32'(tbl[i].val));
            check($sformatf("vec%0d.Ack", i),        32'(Ack),        32'(tbl[i].ack));
            check($sformatf("vec%0d.ProgIdx", i),    32'(ProgIdx),    32'(tbl[i].idx));
            check($sformatf("vec%0d.Overrun", i),    32'(Overrun),    32'(tbl[i].ov));
            check($sformatf("vec%0d.CycleCount", i), 32'(CycleCount), 32'(exp_cnt(tbl[i].cnt)));
        end

        // Randomized phase, starting from a fresh reset so the model is aligned
        apply(1, 0, 0);
        st = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) st = ~st;
            hr = ($urandom_range(0, 4) == 0);
            apply(rst, st, hr);
            check("rnd.Run",        32'(Run),        32'(m_phase == P_RUN));
            check("rnd.PcLoadEn",   32'(PcLoadEn),   32'(m_phase == P_LOAD));
            check("rnd.PcLoadVal",  32'(PcLoadVal),  32'(m_val));
            check("rnd.Ack",        32'(Ack),        32'(m_phase == P_DONE));
            check("rnd.ProgIdx",    32'(ProgIdx),    32'(m_idx));
            check("rnd.Overrun",    32'(Overrun),    32'(m_ov));
            check("rnd.CycleCount", 32'(CycleCount), 32'(exp_cnt(m_cnt)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
